// File: rtl/seq_shift_right.sv
// Multi-cycle right shifter (LSR/ASR) for the LEGv8 datapath: shifts at most
// STEP bits per clock under a start/ready/done handshake.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | ready=1, waiting for start; operand/amount/mode captured at accept
//   S_SHIFT | busy=1, shifting work right by min(STEP, remaining) per clock
//   S_DONE  | done=1 for one cycle; outputData holds the new result
module seq_shift_right #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   inputData,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   outputData
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

  state_t             r_state;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   r_result;
  logic [SHAMT_W-1:0] r_remaining;
  logic               r_fill;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;

  logic [SHAMT_W-1:0] w_k;
  logic [WIDTH-1:0]   w_fill_mask;
  logic [WIDTH-1:0]   w_shifted;

  // The final step of a run may be shorter than STEP.
  assign w_k         = (r_remaining < STEP_AMT) ? r_remaining : STEP_AMT;
  assign w_fill_mask = ~({WIDTH{1'b1}} >> w_k);
  assign w_shifted   = (r_work >> w_k) | (r_fill ? w_fill_mask : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_work      <= '0;
      r_result    <= '0;
      r_remaining <= '0;
      r_fill      <= 1'b0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_work      <= inputData;
            r_remaining <= shamt;
            r_fill      <= arith & inputData[WIDTH-1];
            r_state     <= S_SHIFT;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_remaining != '0) begin
            r_work      <= w_shifted;
            r_remaining <= r_remaining - w_k;
          end else begin
            r_result <= r_work;
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready      = r_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign outputData = r_result;

endmodule
